reg_dualrail_fifo: RTL
======================

REG_DUALRAIL_FIFO -- requirements
Module: reg_dualrail_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data bits per word; dual-rail buses are 2*WIDTH wires.
REQ-002 Parameter DEPTH, default 4: FIFO word capacity; power of two, >= 2.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 hab  input  1  capture enable; 0 blocks new input captures.
REQ-006 in  input  2*WIDTH  dual-rail input word; bit i is in[2i] (false rail) and in[2i+1] (true rail).
REQ-007 ack_in  output  1  four-phase acknowledge to the sender.
REQ-008 out  output  2*WIDTH  dual-rail output word, same pairing as in.
REQ-009 ack_out  input  1  four-phase acknowledge from the receiver.
REQ-010 count  output  $clog2(DEPTH)+1  words stored.
REQ-011 full / empty  output  1 each  count==DEPTH / count==0.
REQ-012 err  output  1  sticky flag: illegal input code seen.

Function
REQ-013 Every in wire and ack_out SHALL pass through a 2-flop synchroniser; all decisions SHALL use only synchronised values.
REQ-014 Pair codes: 00 = NULL, 01 = logic 0, 10 = logic 1 (true rail high), 11 = illegal; a word is DATA-complete when all pairs are 01 or 10, and NULL when all pairs are 00.
REQ-015 Any synchronised 11 pair SHALL set err on the next edge; err stays set until reset.
REQ-016 A word containing a 11 pair SHALL never be captured.
REQ-017 Input FSM, state IN_NULL (ack_in=0): if hab=1, word DATA-complete and full=0, then write the decoded word (true rails) at wr_ptr, set ack_in=1, go to IN_DATA.
REQ-018 In IN_NULL, a complete word with full=1 or hab=0 SHALL be held off: no write, ack_in stays 0, state unchanged.
REQ-019 Input FSM, state IN_DATA (ack_in=1): when the word is NULL, set ack_in=0 and go to IN_NULL; hab does not affect this transition.
REQ-020 Latency: ack_in SHALL rise on the 3rd rising edge after in becomes complete and stable (2 synchroniser edges + 1 capture edge).
REQ-021 Output FSM, state OUT_IDLE (out all 0): if empty=0 and synchronised ack_out=0, drive out with the head word (bit 1 -> 10, bit 0 -> 01) and go to OUT_DATA.
REQ-022 OUT_DATA: hold out; when synchronised ack_out=1, drive out to all 0, pop the head (rd_ptr+1) and go to OUT_RTZ.
REQ-023 OUT_RTZ: out all 0; when synchronised ack_out=0, go to OUT_IDLE.
REQ-024 A word written into an empty FIFO at edge E SHALL appear on out at edge E+1 if the output FSM is in OUT_IDLE with ack_out low.
REQ-025 out SHALL change only between all-NULL and one complete word, never between two DATA words directly.
REQ-026 wr_ptr and rd_ptr SHALL wrap modulo DEPTH.
REQ-027 A write and a pop on the same edge SHALL leave count unchanged; when full, a pop frees one slot for the next edge's write.
REQ-028 Word order SHALL be preserved FIFO.

Reset
REQ-029 With rst_n=0, asynchronously: out=all 0, ack_in=0, count=0, empty=1, full=0, err=0, pointers=0, synchronisers=0, FSMs in IN_NULL and OUT_IDLE.
REQ-030 Reset during any handshake phase SHALL discard stored words; after release, the FSMs restart from IN_NULL and OUT_IDLE.

Verification
REQ-031 Single token: WIDTH=8, in pairs encode 0xA5, ack_out=0 -> ack_in=1 on the 3rd edge; out=0x9966 (pairs 10,01,10,01,01,10,01,10 MSB first); ack_out high -> out=0, count=0.
REQ-032 Fill: DEPTH=4, send 5 tokens with ack_out held 0 and the first word left unacknowledged -> full=1 after 4 captures, 5th ack_in stays 0; ack_out handshake -> 5th captured, order preserved.
REQ-033 Illegal code: in pair 0 = 11, others valid -> err=1, no capture, ack_in=0; correct the pair to 10 -> capture proceeds, err remains 1.
REQ-034 hab=0 with a complete word -> no capture for 20 cycles; hab=1 -> ack_in rises 1 edge later.
REQ-035 Simultaneous: count=2, capture and pop on the same edge -> count stays 2; pointer wrap checked over 9 tokens with DEPTH=4.
REQ-036 Reset asserted in IN_DATA/OUT_DATA with count=3 -> immediately out=0, ack_in=0, count=0, empty=1.

Source files
------------

// File: rtl/reg_dualrail_fifo.sv
// reg_dualrail_fifo: clocked FIFO between two four-phase dual-rail links.
// The input side synchronises the incoming rails, captures DATA-complete
// words into a small register file and acknowledges them. The output side
// presents the head word as a dual-rail code, waits for the receiver's
// acknowledge, then returns to NULL before offering the next word.
module reg_dualrail_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hab,
    input  logic [2*WIDTH-1:0]       in,
    output logic                     ack_in,
    output logic [2*WIDTH-1:0]       out,
    input  logic                     ack_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IN_NULL,
        IN_DATA
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_DATA,
        OUT_RTZ
    } out_state_e;

    // Each plain bit becomes a rail pair: 1 -> true rail (10), 0 -> false rail (01).
    function automatic logic [2*WIDTH-1:0] encode_word(input logic [WIDTH-1:0] data);
        logic [2*WIDTH-1:0] rails;
        rails = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rails[2*i +: 2] = data[i] ? 2'b10 : 2'b01;
        end
        return rails;
    endfunction

    logic [2*WIDTH-1:0] in_s1_q, in_s2_q;
    logic               ack_s1_q, ack_s2_q;

    in_state_e          in_state_q, in_state_d;
    out_state_e         out_state_q, out_state_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               err_q;

    logic               wr_en, pop;
    logic               word_illegal, word_complete, word_null;
    logic [WIDTH-1:0]   word_data;
    logic               full_w, empty_w;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Two-flop synchronisers on every input rail and on the receiver acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_s1_q  <= '0;
            in_s2_q  <= '0;
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
        end else begin
            in_s1_q  <= in;
            in_s2_q  <= in_s1_q;
            ack_s1_q <= ack_out;
            ack_s2_q <= ack_s1_q;
        end
    end

    // Classify the synchronised word: any 11 pair is illegal, complete means
    // exactly one rail high in every pair, NULL means every rail low.
    always_comb begin
        word_illegal  = 1'b0;
        word_complete = 1'b1;
        word_null     = 1'b1;
        word_data     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_s2_q[2*i +: 2] == 2'b11) word_illegal = 1'b1;
            if (in_s2_q[2*i] == in_s2_q[2*i+1]) word_complete = 1'b0;
            if (in_s2_q[2*i +: 2] != 2'b00) word_null = 1'b0;
            word_data[i] = in_s2_q[2*i+1];
        end
    end

    // Input FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_state_q <= IN_NULL;
        else        in_state_q <= in_state_d;
    end

    // Input FSM: capture a complete word when enabled and not full, then wait for NULL.
    always_comb begin
        in_state_d = in_state_q;
        wr_en      = 1'b0;
        unique case (in_state_q)
            IN_NULL: begin
                if (hab && word_complete && !full_w) begin
                    wr_en      = 1'b1;
                    in_state_d = IN_DATA;
                end
            end
            IN_DATA: begin
                if (word_null) in_state_d = IN_NULL;
            end
            default: in_state_d = IN_NULL;
        endcase
    end

    // Output FSM state register and the registered output rails.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q <= OUT_IDLE;
            out_q       <= '0;
        end else begin
            out_state_q <= out_state_d;
            out_q       <= out_d;
        end
    end

    // Output FSM: offer the head word, drop to NULL and pop on acknowledge,
    // then wait for the acknowledge to return low before the next word.
    always_comb begin
        out_state_d = out_state_q;
        out_d       = out_q;
        pop         = 1'b0;
        unique case (out_state_q)
            OUT_IDLE: begin
                if (!empty_w && !ack_s2_q) begin
                    out_d       = encode_word(mem_q[rd_ptr_q]);
                    out_state_d = OUT_DATA;
                end
            end
            OUT_DATA: begin
                if (ack_s2_q) begin
                    out_d       = '0;
                    pop         = 1'b1;
                    out_state_d = OUT_RTZ;
                end
            end
            OUT_RTZ: begin
                if (!ack_s2_q) out_state_d = OUT_IDLE;
            end
            default: begin
                out_d       = '0;
                out_state_d = OUT_IDLE;
            end
        endcase
    end

    // Occupancy: a simultaneous write and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and the sticky illegal-code flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (word_illegal) err_q <= 1'b1;
        end
    end

    // Word storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= word_data;
    end

    assign ack_in = (in_state_q == IN_DATA);
    assign out    = out_q;
    assign count  = count_q;
    assign full   = full_w;
    assign empty  = empty_w;
    assign err    = err_q;

endmodule
